// File: rtl/prog_loader_if.sv
// Stream, status and instruction-fetch signals of the program loader.
// The loader takes the slave modport; the stream source / processor side takes master.
interface prog_loader_if;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_nibble;
    logic        in_ready;
    logic [3:0]  instr_addr;
    logic [11:0] instr;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  load_len;

    modport master (
        output start, in_valid, in_nibble, instr_addr,
        input  in_ready, instr, cpu_rst, busy, done, err, load_len
    );

    modport slave (
        input  start, in_valid, in_nibble, instr_addr,
        output in_ready, instr, cpu_rst, busy, done, err, load_len
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader and 16x12 writable instruction store for the 16x4 processor.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum nibble.
module prog_loader (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_N2   = 3'd2;
    localparam logic [2:0] S_N1   = 3'd3;
    localparam logic [2:0] S_N0   = 3'd4;
    localparam logic [2:0] S_CHK  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    logic [2:0]  state;
    logic [3:0]  lenM1;
    logic [3:0]  hiNib;
    logic [3:0]  midNib;
    logic [4:0]  loadLen;
    logic [11:0] ram [16];

    logic        inReady;
    logic        xfer;
    logic        ramWe;
    logic [3:0]  ramAddr;
    logic [11:0] ramWd;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [3:0]  xorAcc;
`endif

    assign inReady = (state == S_LEN) || (state == S_N2) || (state == S_N1) ||
                     (state == S_N0)  || (state == S_CHK);
    assign xfer    = bus.in_valid && inReady;

    assign ramWe   = xfer && (state == S_N0);
    assign ramAddr = loadLen[3:0];
    assign ramWd   = {hiNib, midNib, bus.in_nibble};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            lenM1   <= 4'd0;
            hiNib   <= 4'd0;
            midNib  <= 4'd0;
            loadLen <= 5'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state   <= S_LEN;
                        loadLen <= 5'd0;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        lenM1 <= bus.in_nibble;
                        state <= S_N2;
                    end
                end
                S_N2: begin
                    if (xfer) begin
                        hiNib <= bus.in_nibble;
                        state <= S_N1;
                    end
                end
                S_N1: begin
                    if (xfer) begin
                        midNib <= bus.in_nibble;
                        state  <= S_N0;
                    end
                end
                S_N0: begin
                    if (xfer) begin
                        loadLen <= loadLen + 5'd1;
                        if (loadLen[3:0] == lenM1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state <= S_DONE;
`endif
                        end else begin
                            state <= S_N2;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        state <= (bus.in_nibble == xorAcc) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR covers the length nibble and every instruction nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xorAcc <= 4'd0;
        end else if (bus.start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR))) begin
            xorAcc <= 4'd0;
        end else if (xfer) begin
            xorAcc <= xorAcc ^ bus.in_nibble;
        end
    end
`endif

    // Store is never reset; load_len masks stale entries on the read side.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram[ramAddr] <= ramWd;
        end
    end

    assign bus.instr    = ({1'b0, bus.instr_addr} < loadLen) ? ram[bus.instr_addr] : 12'h000;
    assign bus.in_ready = inReady;
    assign bus.busy     = inReady;
    assign bus.done     = (state == S_DONE);
    assign bus.cpu_rst  = (state != S_DONE);
    assign bus.load_len = loadLen;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign bus.err      = (state == S_ERR);
`else
    assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random program streams against a
// high-level model (expected store contents, length and checksum).
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if bus();

    prog_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [11:0] expMem [16];
    int          expLen = 0;
    logic [3:0]  stream [$];

    // Turn a list of instructions into the nibble stream a source would send.
    task automatic build_stream(input logic [11:0] w[$], input bit badChk);
        logic [3:0] chk;
        stream.delete();
        stream.push_back(4'(w.size() - 1));
        foreach (w[i]) begin
            stream.push_back(w[i][11:8]);
            stream.push_back(w[i][7:4]);
            stream.push_back(w[i][3:0]);
        end
        chk = 4'd0;
        foreach (stream[i]) chk = chk ^ stream[i];
        if (badChk) chk = chk ^ 4'($urandom_range(1, 15));
`ifdef PROG_LOADER_CHECKSUM_EN
        stream.push_back(chk);
`endif
    endtask

    task automatic set_model(input logic [11:0] w[$]);
        expLen = w.size();
        foreach (w[i]) expMem[i] = w[i];
    endtask

    task automatic begin_load();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Offers one nibble until accepted; returns 1 time unit after the accepting edge.
    task automatic send_nibble(input logic [3:0] n, input bit randValid, input bit pulseStart);
        int waited;
        bit acc;
        waited = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            bus.start = pulseStart && (waited == 0);
            if (randValid && ($urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid  = 1'b1;
                bus.in_nibble = n;
                acc = bus.in_ready;
            end
            @(posedge clk);
            #1 bus.start = 1'b0;
            waited++;
            if (!acc && waited > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout nibble=%h in_ready=%b never accepted", n, bus.in_ready);
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.cpu_rst, bus.busy, bus.done, bus.err} !== 5'b01000) begin
            failures++;
            $display("FAIL reset_flags got ready/cpu_rst/busy/done/err=%b want=01000",
                     {bus.in_ready, bus.cpu_rst, bus.busy, bus.done, bus.err});
        end
        checks++;
        if (bus.load_len !== 5'd0) begin
            failures++;
            $display("FAIL reset_load_len got=%0d want=0", bus.load_len);
        end
        for (int a = 0; a < 16; a++) begin
            bus.instr_addr = 4'(a);
            #1;
            checks++;
            if (bus.instr !== 12'h000) begin
                failures++;
                $display("FAIL reset_instr addr=%0d got=%h want=000", a, bus.instr);
            end
        end
    endtask

    task automatic test_basic();
        logic [11:0] w[$];
        logic [11:0] e;
        w = '{12'h835, 12'h034};
        build_stream(w, 1'b0);
        bus.instr_addr = 4'd0;
        begin_load();
        checks++;
        if ({bus.busy, bus.in_ready, bus.cpu_rst, bus.done} !== 4'b1110 || bus.load_len !== 5'd0) begin
            failures++;
            $display("FAIL basic_start busy/ready/cpu_rst/done=%b len=%0d want=1110 len=0",
                     {bus.busy, bus.in_ready, bus.cpu_rst, bus.done}, bus.load_len);
        end
        foreach (stream[i]) begin
            send_nibble(stream[i], 1'b0, 1'b0);
            if (i == 3) begin
                checks++;
                if (bus.load_len !== 5'd1 || bus.instr !== 12'h835) begin
                    failures++;
                    $display("FAIL basic_first_write len=%0d instr=%h want len=1 instr=835",
                             bus.load_len, bus.instr);
                end
            end
        end
        checks++;
        if ({bus.done, bus.cpu_rst, bus.busy, bus.err} !== 4'b1000 || bus.load_len !== 5'd2) begin
            failures++;
            $display("FAIL basic_done done/cpu_rst/busy/err=%b len=%0d want=1000 len=2",
                     {bus.done, bus.cpu_rst, bus.busy, bus.err}, bus.load_len);
        end
        bus.in_valid = 1'b0;
        set_model(w);
        for (int a = 0; a < 16; a++) begin
            bus.instr_addr = 4'(a);
            #1;
            e = (a < expLen) ? expMem[a] : 12'h000;
            checks++;
            if (bus.instr !== e) begin
                failures++;
                $display("FAIL basic_read addr=%0d got=%h want=%h", a, bus.instr, e);
            end
        end
    endtask

    task automatic test_random_loads();
        logic [11:0] w[$];
        logic [11:0] e;
        int n;
        for (int t = 0; t < 5; t++) begin
            w.delete();
            if (t == 0) begin
                w = '{12'h835, 12'h034};
            end else begin
                n = $urandom_range(1, 16);
                for (int i = 0; i < n; i++) w.push_back(12'($urandom));
            end
            build_stream(w, 1'b0);
            begin_load();
            foreach (stream[i]) send_nibble(stream[i], 1'b1, (i == 3) || (i == 5));
            checks++;
            if (bus.done !== 1'b1 || bus.cpu_rst !== 1'b0 || bus.load_len !== 5'(w.size())) begin
                failures++;
                $display("FAIL random_done t=%0d done=%b cpu_rst=%b len=%0d want done=1 cpu_rst=0 len=%0d",
                         t, bus.done, bus.cpu_rst, bus.load_len, w.size());
            end
            bus.in_valid = 1'b0;
            set_model(w);
            for (int a = 0; a < 16; a++) begin
                bus.instr_addr = 4'(a);
                #1;
                e = (a < expLen) ? expMem[a] : 12'h000;
                checks++;
                if (bus.instr !== e) begin
                    failures++;
                    $display("FAIL random_read t=%0d addr=%0d got=%h want=%h", t, a, bus.instr, e);
                end
            end
        end
    endtask

    task automatic test_full16();
        logic [11:0] w[$];
        logic [11:0] e;
        for (int i = 0; i < 16; i++) w.push_back({4'h8, 4'(i), ~4'(i)});
        build_stream(w, 1'b0);
        begin_load();
        foreach (stream[i]) send_nibble(stream[i], 1'b0, 1'b0);
        checks++;
        if (bus.load_len !== 5'd16 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL full_len len=%0d done=%b want len=16 done=1", bus.load_len, bus.done);
        end
        set_model(w);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_nibble = 4'h5;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_extra_ready got=%b want=0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.load_len !== 5'd16 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL full_extra_nibble len=%0d done=%b want len=16 done=1", bus.load_len, bus.done);
        end
        bus.in_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            bus.instr_addr = 4'(a);
            #1;
            e = (a < expLen) ? expMem[a] : 12'h000;
            checks++;
            if (bus.instr !== e) begin
                failures++;
                $display("FAIL full_read addr=%0d got=%h want=%h", a, bus.instr, e);
            end
        end
    endtask

    task automatic test_bad_checksum();
        logic [11:0] w[$];
        w.push_back(12'($urandom));
        build_stream(w, 1'b1);
        begin_load();
        foreach (stream[i]) send_nibble(stream[i], 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.err, bus.done, bus.cpu_rst, bus.busy} !== 4'b1010 || bus.load_len !== 5'd1) begin
            failures++;
            $display("FAIL chk_bad err/done/cpu_rst/busy=%b len=%0d want=1010 len=1",
                     {bus.err, bus.done, bus.cpu_rst, bus.busy}, bus.load_len);
        end
        w.delete();
        w.push_back(12'($urandom));
        w.push_back(12'($urandom));
        build_stream(w, 1'b0);
        begin_load();
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL chk_restart err=%b busy=%b want err=0 busy=1", bus.err, bus.busy);
        end
        foreach (stream[i]) send_nibble(stream[i], 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.err, bus.done, bus.cpu_rst} !== 3'b010 || bus.load_len !== 5'd2) begin
            failures++;
            $display("FAIL chk_good err/done/cpu_rst=%b len=%0d want=010 len=2",
                     {bus.err, bus.done, bus.cpu_rst}, bus.load_len);
        end
        set_model(w);
    endtask

    task automatic test_rst_midload();
        logic [11:0] w[$];
        logic [11:0] e;
        for (int i = 0; i < 16; i++) w.push_back(12'($urandom));
        build_stream(w, 1'b0);
        begin_load();
        for (int i = 0; i < 4; i++) send_nibble(stream[i], 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        expLen = 0;
        checks++;
        if (bus.load_len !== 5'd0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid len=%0d ready=%b busy=%b cpu_rst=%b want len=0 ready=0 busy=0 cpu_rst=1",
                     bus.load_len, bus.in_ready, bus.busy, bus.cpu_rst);
        end
        for (int a = 0; a < 16; a++) begin
            bus.instr_addr = 4'(a);
            #1;
            checks++;
            if (bus.instr !== 12'h000) begin
                failures++;
                $display("FAIL rst_mid_read addr=%0d got=%h want=000", a, bus.instr);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        begin_load();
        foreach (stream[i]) send_nibble(stream[i], 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.load_len !== 5'd16) begin
            failures++;
            $display("FAIL rst_reload done=%b len=%0d want done=1 len=16", bus.done, bus.load_len);
        end
        set_model(w);
        for (int a = 0; a < 16; a++) begin
            bus.instr_addr = 4'(a);
            #1;
            e = (a < expLen) ? expMem[a] : 12'h000;
            checks++;
            if (bus.instr !== e) begin
                failures++;
                $display("FAIL rst_reload_read addr=%0d got=%h want=%h", a, bus.instr, e);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_nibble  = 4'd0;
        bus.instr_addr = 4'd0;
        test_reset();
        test_basic();
        test_random_loads();
        test_full16();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_rst_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
